// File: rtl/ahb_slave_mux.sv
// AHB-Lite response multiplexer: routes HRDATA/HREADY/HRESP from the data-phase
// slave and supplies a default-slave two-cycle ERROR for unmapped or multi-hot selects.
module ahb_slave_mux #(
    parameter int unsigned NUM_SLV   = 3,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SLV-1:0]          HSEL,
    input  logic [1:0]                  HTRANS,
    input  logic [NUM_SLV*DATA_W-1:0]   HRDATA_S,
    input  logic [NUM_SLV-1:0]          HREADYOUT_S,
    input  logic [NUM_SLV-1:0]          HRESP_S,
    output logic [DATA_W-1:0]           HRDATA,
    output logic                        HREADY,
    output logic                        HRESP,
    output logic [ERR_CNT_W-1:0]        err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t             state;
    logic [NUM_SLV-1:0] dsel;
    logic               active;
    logic               onehot;
    logic               dec_err;

    assign active  = HTRANS[1];
    // Non-zero with no second bit set: clearing the lowest set bit leaves zero.
    assign onehot  = (HSEL != '0) && ((HSEL & (HSEL - NUM_SLV'(1))) == '0);
    assign dec_err = active && !onehot;

    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        if (dsel != '0) begin
            for (int unsigned i = 0; i < NUM_SLV; i++) begin
                if (dsel[i]) begin
                    HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
                    HREADY = HREADYOUT_S[i];
                    HRESP  = HRESP_S[i];
                end
            end
        end else begin
            case (state)
                ST_ERR1: begin
                    HREADY = 1'b0;
                    HRESP  = 1'b1;
                end
                ST_ERR2: begin
                    HREADY = 1'b1;
                    HRESP  = 1'b1;
                end
                default: begin
                    HREADY = 1'b1;
                    HRESP  = 1'b0;
                end
            endcase
        end
    end

    // ERR1 always drives HREADY low, so the capture branch is only reached from IDLE or ERR2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            dsel    <= '0;
            err_cnt <= '0;
        end else if (HREADY) begin
            dsel <= onehot ? HSEL : '0;
            if (dec_err) begin
                state <= ST_ERR1;
                if (err_cnt != '1)
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
            end else begin
                state <= ST_IDLE;
            end
        end else if (state == ST_ERR1) begin
            state <= ST_ERR2;
        end
    end

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Directed bench for ahb_slave_mux: routing, wait states, default-slave errors,
// reset mid-error and counter saturation (counter width 2).
module tb_ahb_slave_mux;

    localparam int unsigned NS = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 2;

    logic              clk;
    logic              rst_n;
    logic [NS-1:0]     HSEL;
    logic [1:0]        HTRANS;
    logic [NS*DW-1:0]  HRDATA_S;
    logic [NS-1:0]     HREADYOUT_S;
    logic [NS-1:0]     HRESP_S;
    logic [DW-1:0]     HRDATA;
    logic              HREADY;
    logic              HRESP;
    logic [CW-1:0]     err_cnt;

    int total = 0;
    int bad   = 0;

    ahb_slave_mux #(.NUM_SLV(NS), .DATA_W(DW), .ERR_CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .HSEL        (HSEL),
        .HTRANS      (HTRANS),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive next address phase, let the combinational outputs settle.
    task automatic drive(input logic [1:0] tr, input logic [NS-1:0] sel);
        HTRANS = tr;
        HSEL   = sel;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic check_out(input string tag, input logic [DW-1:0] d, input logic r, input logic e);
        check({tag, ".hrdata"}, 64'(HRDATA), 64'(d));
        check({tag, ".hready"}, 64'(HREADY), 64'(r));
        check({tag, ".hresp"},  64'(HRESP),  64'(e));
    endtask

    initial begin
        rst_n       = 1'b0;
        HSEL        = '0;
        HTRANS      = 2'b00;
        HRDATA_S    = {32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_1111};
        HREADYOUT_S = 3'b111;
        HRESP_S     = 3'b000;
        #1;
        check_out("reset", 32'h0, 1'b1, 1'b0);
        check("reset.cnt", 64'(err_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pipelined routing slave 1 then slave 2
        drive(2'b10, 3'b010);
        check_out("rt.idle", 32'h0, 1'b1, 1'b0);
        next_cycle();
        drive(2'b10, 3'b100);
        check_out("rt.s1", 32'hDEAD_BEEF, 1'b1, 1'b0);
        next_cycle();
        drive(2'b00, 3'b000);
        check_out("rt.s2", 32'h2222_2222, 1'b1, 1'b0);
        next_cycle();
        check_out("rt.back", 32'h0, 1'b1, 1'b0);

        // Slave 0 wait-stated for 3 cycles while slave 2 is presented
        drive(2'b10, 3'b001);
        next_cycle();
        HREADYOUT_S = 3'b110;
        drive(2'b10, 3'b100);
        for (int k = 0; k < 3; k++) begin
            check_out("ws.wait", 32'h0000_1111, 1'b0, 1'b0);
            next_cycle();
        end
        HREADYOUT_S = 3'b111;
        #1;
        check_out("ws.done", 32'h0000_1111, 1'b1, 1'b0);
        next_cycle();
        drive(2'b00, 3'b000);
        check_out("ws.s2", 32'h2222_2222, 1'b1, 1'b0);
        next_cycle();

        // Slave ERROR passes through untouched
        drive(2'b10, 3'b100);
        next_cycle();
        drive(2'b00, 3'b000);
        HREADYOUT_S = 3'b011;
        HRESP_S     = 3'b100;
        #1;
        check_out("se.c1", 32'h2222_2222, 1'b0, 1'b1);
        next_cycle();
        HREADYOUT_S = 3'b111;
        #1;
        check_out("se.c2", 32'h2222_2222, 1'b1, 1'b1);
        next_cycle();
        HRESP_S = 3'b000;
        #1;
        check("se.cnt", 64'(err_cnt), 64'd0);

        // Unmapped NONSEQ; a NONSEQ shown during ERR1 must be ignored
        drive(2'b10, 3'b000);
        next_cycle();
        drive(2'b10, 3'b000);
        check_out("um.err1", 32'h0, 1'b0, 1'b1);
        check("um.cnt1", 64'(err_cnt), 64'd1);
        next_cycle();
        drive(2'b00, 3'b000);
        check_out("um.err2", 32'h0, 1'b1, 1'b1);
        next_cycle();
        check_out("um.idle", 32'h0, 1'b1, 1'b0);
        check("um.cnt", 64'(err_cnt), 64'd1);
        next_cycle();
        check_out("um.idle2", 32'h0, 1'b1, 1'b0);
        check("um.cnt2", 64'(err_cnt), 64'd1);

        // Reset asserted in ERR1
        drive(2'b11, 3'b000);
        next_cycle();
        drive(2'b00, 3'b000);
        check("rm.err1", 64'(HREADY), 64'd0);
        rst_n = 1'b0;
        #1;
        check_out("rm.rst", 32'h0, 1'b1, 1'b0);
        check("rm.cnt", 64'(err_cnt), 64'd0);
        next_cycle();
        rst_n = 1'b1;

        // Multi-hot then unmapped presented during ERR2
        drive(2'b10, 3'b011);
        next_cycle();
        drive(2'b00, 3'b000);
        check_out("mh.err1a", 32'h0, 1'b0, 1'b1);
        check("mh.cnt1", 64'(err_cnt), 64'd1);
        next_cycle();
        drive(2'b10, 3'b000);
        check_out("mh.err2a", 32'h0, 1'b1, 1'b1);
        next_cycle();
        drive(2'b00, 3'b000);
        check_out("mh.err1b", 32'h0, 1'b0, 1'b1);
        check("mh.cnt2", 64'(err_cnt), 64'd2);
        next_cycle();
        check_out("mh.err2b", 32'h0, 1'b1, 1'b1);
        next_cycle();
        check_out("mh.idle", 32'h0, 1'b1, 1'b0);
        check("mh.cnt", 64'(err_cnt), 64'd2);

        // Saturation at 3 for a 2-bit counter
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(2'b10, 3'b000);
            next_cycle();
            drive(2'b00, 3'b000);
            check("sat.hready", 64'(HREADY), 64'd0);
            check("sat.cnt", 64'(err_cnt), (k < 2) ? 64'(k + 1) : 64'd3);
            next_cycle();
            check("sat.err2", 64'(HRESP), 64'd1);
            next_cycle();
        end
        check_out("sat.idle", 32'h0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mux.md
# ahb_slave_mux

Parametrised AHB-Lite slave-to-master response multiplexer with integrated default slave. Sits between the address decoder and the master and routes HRDATA/HREADY/HRESP from NUM_SLV slaves. The data-phase select is registered only on completed address phases (HREADY high), so wait-stated transfers keep their routing. Unmapped or multi-hot selects get a standard two-cycle ERROR response, and decode errors are counted.

## Interface
Parameters:
- NUM_SLV, 3: number of slave ports (≥1)
- DATA_W, 32: read data width
- ERR_CNT_W, 8: width of the decode-error counter

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- HSEL  in  NUM_SLV  address-phase slave selects from the decoder; bit i = slave i
- HTRANS  in  2  address-phase transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- HRDATA_S  in  NUM_SLV*DATA_W  slave read data; slave i at bits [i*DATA_W +: DATA_W]
- HREADYOUT_S  in  NUM_SLV  slave ready outputs
- HRESP_S  in  NUM_SLV  slave responses (0 OKAY, 1 ERROR)
- HRDATA  out  DATA_W  read data to the master
- HREADY  out  1  transfer-complete to the master and all slaves
- HRESP  out  1  response to the master
- err_cnt  out  ERR_CNT_W  saturating count of default-slave ERROR responses

## Operation
- Address-phase classification, evaluated each cycle:
  - active = HTRANS[1].
  - onehot = HSEL has exactly one bit set.
  - decode error = active and not onehot, covering both zero and multi-hot HSEL.
- Capture happens only on a rising edge with HREADY (the output) = 1. Nothing is captured when HREADY = 0.
  - onehot → dsel ← HSEL.
  - Otherwise → dsel ← 0.
  - Decode error → FSM IDLE→ERR1.
- Data-phase mux, combinational from dsel and the FSM:
  - dsel bit i set → HRDATA/HREADY/HRESP = slave i's signals.
  - dsel = 0 and FSM IDLE → HRDATA = 0, HREADY = 1, HRESP = 0. This covers no transfer, IDLE/BUSY, and unmapped IDLE/BUSY.
  - FSM ERR1 → HRDATA = 0, HREADY = 0, HRESP = 1.
  - FSM ERR2 → HRDATA = 0, HREADY = 1, HRESP = 1.
- Default-slave FSM (IDLE, ERR1, ERR2):
  - IDLE→ERR1 on a decode error captured with HREADY = 1.
  - ERR1→ERR2 unconditionally.
  - ERR2 has HREADY = 1, so it captures the next address phase. It goes to ERR1 if that phase is another decode error, otherwise to IDLE, with dsel loaded per the capture rule.
  - HTRANS changes during ERR1 (master cancelling to IDLE) are ignored; nothing is captured.
  - A slave ERROR is passed through unchanged. The slave owns its own two-cycle sequence.
- err_cnt:
  - Increments by 1 on each IDLE/ERR2→ERR1 transition.
  - Saturates at 2^ERR_CNT_W−1 and does not wrap.
  - Cleared only by reset.

## Timing
- Reset (async assert, rst_n low):
  - dsel = 0, FSM = IDLE, err_cnt = 0.
  - Outputs immediately HRDATA = 0, HREADY = 1, HRESP = 0.
  - Release is synchronous to the next clk edge; the first capture happens on the first edge with rst_n high.
- Reset mid-transfer (including ERR1, or a slave wait state): all state is cleared at once. The outputs return to the reset values in the same cycle.
- Routing latency: a slave selected in the address phase at edge N drives HRDATA/HREADY/HRESP from edge N until the data-phase edge with HREADY = 1. Outputs are combinational from the slave inputs, with no added cycles.
- Wait states: with HREADYOUT_S[i] = 0, dsel holds and a new HSEL is ignored. Back-to-back pipelined transfers to different slaves switch routing exactly at the completing edge.
- Decode-error latency: exactly 2 data-phase cycles, ERR1 then ERR2.
- Simultaneous events: an ERR2 completion and a new address phase are captured on the same edge. A saturated err_cnt stays at its maximum while the FSM still sequences.

## Test plan
- Reset: assert rst_n = 0 mid-ERR1 → HREADY = 1, HRESP = 0, HRDATA = 0, err_cnt = 0 in the same cycle.
- Routing: NONSEQ with HSEL = 3'b010, then HSEL = 3'b100 next cycle.
  - Slave 1 returns 0xDEADBEEF with HREADYOUT_S = 1 → HRDATA = 0xDEADBEEF in cycle 1 and slave 2's data in cycle 2.
- Wait state hold: slave 0 selected with HREADYOUT_S[0] = 0 for 3 cycles while HSEL changes to 3'b100 → HREADY = 0 for 3 cycles, routing stays on slave 0, then slave 2 is routed after completion.
- Unmapped: NONSEQ with HSEL = 0 → next cycle HREADY = 0, HRESP = 1; following cycle HREADY = 1, HRESP = 1; err_cnt = 1.
  - IDLE with HSEL = 0 → HREADY = 1, HRESP = 0, err_cnt unchanged.
- Multi-hot and back-to-back errors: NONSEQ with HSEL = 3'b011, with another NONSEQ HSEL = 0 presented during ERR2 → ERR1, ERR2, ERR1, ERR2 sequence; err_cnt = 2.
- Saturation: ERR_CNT_W = 2, 5 decode errors → err_cnt sequence 1, 2, 3, 3, 3.
